off_itf_sched: RTL and testbench

//  Host-side scheduler for the off-chip port of TOP; runs in the I_OffClk domain between DRAM and IO_Dat.

---
 rtl/off_itf_pkg.sv | 9 +
 rtl/off_itf_arb.sv | 35 +++
 rtl/off_itf_sched.sv | 98 +++++++++
 tb/tb_off_itf_sched.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/off_itf_pkg.sv
// off_itf_pkg: shared constants, state encoding and command field offsets for the off-chip scheduler
package off_itf_pkg;
  localparam int OP_NUM = 6;
  localparam int MDU_ISA_BASE [OP_NUM] = '{0, 16, 18, 20, 29, 31};
  localparam int MDU_ISA_NUM  [OP_NUM] = '{16, 2, 2, 9, 2, 1};
  localparam int CMD_DIR_BIT  = 0;
  localparam int CMD_BASE_LSB = 1;
  typedef enum logic [2:0] {IDLE, ISASND, DATCMD, DATIN, DATOUT} stateT;
endpackage

// File: rtl/off_itf_arb.sv
// off_itf_arb: N-way ISA request arbiter; ISA_RR_ARB_EN selects round-robin, otherwise lowest index wins
module off_itf_arb
  import off_itf_pkg::*;
#(
  parameter int N = OP_NUM
) (
  input  logic                 I_OffClk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 update,
  output logic [$clog2(N)-1:0] gntIdx,
  output logic                 gntVld
);
  localparam int W = $clog2(N);
  assign gntVld = |req;
`ifdef ISA_RR_ARB_EN
  logic [W-1:0] rrPtr;
  always_comb begin
    gntIdx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(rrPtr) + k) % N]) gntIdx = W'((int'(rrPtr) + k) % N);
  end
  always_ff @(posedge I_OffClk or posedge rst_n)
    if (rst_n) rrPtr <= '0;
    else if (update) rrPtr <= gntIdx == W'(N - 1) ? '0 : gntIdx + 1'b1;
`else
  logic unusedSig;
  assign unusedSig = ^{I_OffClk, rst_n, update};
  always_comb begin
    gntIdx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[k]) gntIdx = W'(k);
  end
`endif
endmodule

// File: rtl/off_itf_sched.sv
// off_itf_sched: host-side off-chip scheduler issuing ISA bursts and servicing chip DRAM read/write commands
// ISA_RR_ARB_EN selects round-robin ISA grants; undefined gives fixed priority (FPS highest)
module off_itf_sched
  import off_itf_pkg::*;
#(
  parameter int PORT_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 16,
  parameter int DRAM_ADDR_WIDTH = 32,
  parameter int OPNUM           = OP_NUM
) (
  input  logic                       I_OffClk,
  input  logic                       rst_n,
  input  logic [OPNUM-1:0]           I_CfgRdy,
  input  logic                       I_CmdVld,
  input  logic                       I_ChipVld,
  output logic                       O_ChipRdy,
  input  logic [PORT_WIDTH-1:0]      I_ChipDat,
  output logic                       O_HostVld,
  input  logic                       I_HostRdy,
  output logic [PORT_WIDTH-1:0]      O_HostDat,
  output logic                       O_HostLast,
  output logic                       O_ISAVld,
  output logic [DRAM_ADDR_WIDTH-1:0] O_MemAddr,
  output logic                       O_MemWrEn,
  output logic [PORT_WIDTH-1:0]      O_MemWrDat,
  input  logic [PORT_WIDTH-1:0]      I_MemRdDat,
  output logic [$clog2(OPNUM)-1:0]   O_GntIdx,
  output logic                       O_Err
);
  localparam int LEN_LSB = CMD_BASE_LSB + DRAM_ADDR_WIDTH;
  stateT state, nxtState;
  logic [ADDR_WIDTH-1:0] isaPtr [OPNUM];
  logic [ADDR_WIDTH-1:0] beatCnt, remain, cmdLen;
  logic [DRAM_ADDR_WIDTH-1:0] addr, cmdBase;
  logic [$clog2(OPNUM)-1:0] arbIdx;
  logic arbVld, grant, hostFire, cmdDir;
  off_itf_arb #(.N(OPNUM)) uArb (
    .I_OffClk(I_OffClk), .rst_n(rst_n), .req(I_CfgRdy), .update(grant),
    .gntIdx(arbIdx), .gntVld(arbVld)
  );
  assign cmdDir     = I_ChipDat[CMD_DIR_BIT];
  assign cmdBase    = I_ChipDat[CMD_BASE_LSB +: DRAM_ADDR_WIDTH];
  assign cmdLen     = I_ChipDat[LEN_LSB +: ADDR_WIDTH];
  assign grant      = state == IDLE && !I_CmdVld && arbVld;
  assign O_HostVld  = state == ISASND || state == DATIN;
  assign O_ISAVld   = state == ISASND;
  assign O_ChipRdy  = state == DATCMD || state == DATOUT;
  assign hostFire   = O_HostVld && I_HostRdy;
  assign O_HostDat  = O_HostVld ? I_MemRdDat : '0;
  assign O_HostLast = state == ISASND ? beatCnt == ADDR_WIDTH'(MDU_ISA_NUM[O_GntIdx] - 1)
                                      : state == DATIN && remain == ADDR_WIDTH'(1);
  assign O_MemAddr  = state == ISASND ? DRAM_ADDR_WIDTH'(isaPtr[O_GntIdx])
                    : (state == DATIN || state == DATOUT) ? addr : '0;
  assign O_MemWrEn  = state == DATOUT && I_ChipVld;
  assign O_MemWrDat = I_ChipDat;
  always_comb begin
    nxtState = state;
    case (state)
      IDLE:    nxtState = I_CmdVld ? DATCMD : arbVld ? ISASND : IDLE;
      ISASND:  nxtState = hostFire && O_HostLast ? IDLE : ISASND;
      DATCMD:  nxtState = !I_ChipVld ? DATCMD : cmdLen == '0 ? IDLE : cmdDir ? DATOUT : DATIN;
      DATIN:   nxtState = hostFire && O_HostLast ? IDLE : DATIN;
      DATOUT:  nxtState = I_ChipVld && remain == ADDR_WIDTH'(1) ? IDLE : DATOUT;
      default: nxtState = IDLE;
    endcase
  end
  always_ff @(posedge I_OffClk or posedge rst_n)
    if (rst_n) state <= IDLE;
    else state <= nxtState;
  // ISA pointers persist across bursts so each grant continues where that module left off
  always_ff @(posedge I_OffClk or posedge rst_n)
    if (rst_n) begin
      O_GntIdx <= '0;
      beatCnt  <= '0;
      remain   <= '0;
      addr     <= '0;
      O_Err    <= 1'b0;
      for (int i = 0; i < OPNUM; i++) isaPtr[i] <= ADDR_WIDTH'(MDU_ISA_BASE[i]);
    end else begin
      if (grant) begin
        O_GntIdx <= arbIdx;
        beatCnt  <= '0;
      end
      if (state == ISASND && hostFire) begin
        isaPtr[O_GntIdx] <= isaPtr[O_GntIdx] + 1'b1;
        beatCnt          <= beatCnt + 1'b1;
      end
      if (state == DATCMD && I_ChipVld) begin
        O_Err  <= O_Err || cmdLen == '0;
        addr   <= cmdBase;
        remain <= cmdLen;
      end
      if ((state == DATIN && hostFire) || O_MemWrEn) begin
        addr   <= addr + 1'b1;
        remain <= remain - 1'b1;
      end
    end
endmodule

// File: tb/tb_off_itf_sched.sv
// tb_off_itf_sched: directed table and sequence checks for off_itf_sched
module tb_off_itf_sched;
  localparam int PW = 128, AW = 16, DW = 32, OPN = 6;
  logic I_OffClk, rst_n, I_CmdVld, I_ChipVld, I_HostRdy;
  logic [OPN-1:0] I_CfgRdy;
  logic [PW-1:0] I_ChipDat, I_MemRdDat;
  logic O_ChipRdy, O_HostVld, O_HostLast, O_ISAVld, O_MemWrEn, O_Err;
  logic [PW-1:0] O_HostDat, O_MemWrDat;
  logic [DW-1:0] O_MemAddr;
  logic [2:0] O_GntIdx;
  int nChk = 0, nPass = 0;

  off_itf_sched dut (
    .I_OffClk(I_OffClk), .rst_n(rst_n), .I_CfgRdy(I_CfgRdy), .I_CmdVld(I_CmdVld),
    .I_ChipVld(I_ChipVld), .O_ChipRdy(O_ChipRdy), .I_ChipDat(I_ChipDat),
    .O_HostVld(O_HostVld), .I_HostRdy(I_HostRdy), .O_HostDat(O_HostDat),
    .O_HostLast(O_HostLast), .O_ISAVld(O_ISAVld), .O_MemAddr(O_MemAddr),
    .O_MemWrEn(O_MemWrEn), .O_MemWrDat(O_MemWrDat), .I_MemRdDat(I_MemRdDat),
    .O_GntIdx(O_GntIdx), .O_Err(O_Err)
  );

  function automatic logic [PW-1:0] dram(input logic [DW-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_0F0F, a + 32'd7};
  endfunction
  assign I_MemRdDat = dram(O_MemAddr);

  initial I_OffClk = 1'b0;
  always #5 I_OffClk = ~I_OffClk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic runIsa(input logic [5:0] req, input logic [5:0] reqAfter, input int idx,
                        input int start, input int len, output int waits);
    logic [DW-1:0] a;
    I_CfgRdy = req;
    waits = 0;
    do begin @(negedge I_OffClk); waits++; end while (!O_HostVld && waits < 6);
    I_CfgRdy = reqAfter;
    for (int b = 0; b < len; b++) begin
      if (b > 0) @(negedge I_OffClk);
      a = DW'(start + b);
      chk($sformatf("isa%0d_b%0d_ctl", idx, b),
          {O_HostVld, O_ISAVld, O_HostLast, O_GntIdx, O_MemAddr},
          {1'b1, 1'b1, b == len - 1, 3'(idx), a});
      chk($sformatf("isa%0d_b%0d_dat", idx, b), O_HostDat, dram(a));
    end
    @(negedge I_OffClk);
    chk($sformatf("isa%0d_idle_gap", idx), O_HostVld, 1'b0);
  endtask

  task automatic sendCmd(input logic dir, input logic [DW-1:0] base, input logic [AW-1:0] len);
    int w;
    w = 0;
    I_CmdVld = 1'b1;
    do begin @(negedge I_OffClk); w++; end while (!O_ChipRdy && w < 6);
    chk("cmd_accept", {O_ChipRdy, O_HostVld, O_MemWrEn}, 3'b100);
    I_ChipDat = '0;
    I_ChipDat[0] = dir;
    I_ChipDat[32:1] = base;
    I_ChipDat[48:33] = len;
    I_ChipVld = 1'b1;
    I_CmdVld = 1'b0;
    @(negedge I_OffClk);
    I_ChipVld = 1'b0;
    I_ChipDat = '0;
  endtask

  typedef struct {
    logic [5:0] req;
    int idx;
    int start;
    int len;
  } isaVecT;
  isaVecT vecs [10];

  initial begin
    int waits, done;
    logic [PW-1:0] wd;
    vecs[0] = '{6'b000001, 0, 0, 16};
    vecs[1] = '{6'b000010, 1, 16, 2};
    vecs[2] = '{6'b000010, 1, 18, 2};
    vecs[3] = '{6'b000100, 2, 18, 2};
    vecs[4] = '{6'b001000, 3, 20, 9};
    vecs[5] = '{6'b010000, 4, 29, 2};
    vecs[6] = '{6'b100000, 5, 31, 1};
    vecs[7] = '{6'b000001, 0, 16, 16};
    vecs[8] = '{6'b001010, 1, 20, 2};
    vecs[9] = '{6'b110000, 4, 31, 2};
    rst_n = 1'b1;
    I_CfgRdy = '0;
    I_CmdVld = 1'b0;
    I_ChipVld = 1'b0;
    I_ChipDat = '0;
    I_HostRdy = 1'b1;
    repeat (2) @(negedge I_OffClk);
    chk("rst_ctl", {O_HostVld, O_ISAVld, O_HostLast, O_ChipRdy, O_MemWrEn, O_Err}, 6'b0);
    chk("rst_addr", O_MemAddr, 32'h0);
    chk("rst_gnt", O_GntIdx, 3'd0);
    chk("rst_dat", O_HostDat, '0);
    rst_n = 1'b0;

    for (int v = 0; v < 10; v++) begin
      runIsa(vecs[v].req, 6'b0, vecs[v].idx, vecs[v].start, vecs[v].len, waits);
      chk($sformatf("vec%0d_latency", v), 32'(waits), 32'd1);
    end

    sendCmd(1'b0, 32'h100, 16'd4);
    done = 0;
    for (int c = 0; c < 12 && done < 4; c++) begin
      chk($sformatf("din_b%0d_c%0d_ctl", done, c),
          {O_HostVld, O_ISAVld, O_HostLast, O_MemAddr},
          {1'b1, 1'b0, done == 3, 32'h100 + 32'(done)});
      chk($sformatf("din_b%0d_c%0d_dat", done, c), O_HostDat, dram(32'h100 + 32'(done)));
      I_HostRdy = (c % 2 == 0);
      @(negedge I_OffClk);
      if (I_HostRdy) done++;
    end
    chk("din_beats", 32'(done), 32'd4);
    chk("din_idle", {O_HostVld, O_ChipRdy}, 2'b00);
    I_HostRdy = 1'b1;

    sendCmd(1'b1, 32'h200, 16'd3);
    for (int k = 0; k < 3; k++) begin
      wd = {4{32'hC0DE_0000 + 32'(k)}};
      I_ChipVld = 1'b1;
      I_ChipDat = wd;
      #1;
      chk($sformatf("dout_b%0d_ctl", k), {O_ChipRdy, O_MemWrEn, O_HostVld, O_MemAddr},
          {1'b1, 1'b1, 1'b0, 32'h200 + 32'(k)});
      chk($sformatf("dout_b%0d_dat", k), O_MemWrDat, wd);
      @(negedge I_OffClk);
    end
    #1;
    chk("dout_after", {O_ChipRdy, O_MemWrEn}, 2'b00);
    I_ChipVld = 1'b0;
    I_ChipDat = '0;

    chk("err_before", O_Err, 1'b0);
    sendCmd(1'b0, 32'h50, 16'd0);
    chk("err_set", {O_Err, O_HostVld, O_ChipRdy}, 3'b100);
    @(negedge I_OffClk);
    chk("err_sticky", {O_Err, O_HostVld, O_ChipRdy}, 3'b100);

    I_CfgRdy = 6'b000001;
    repeat (4) @(negedge I_OffClk);
    chk("mid_burst_active", {O_HostVld, O_ISAVld}, 2'b11);
    I_CfgRdy = '0;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ctl", {O_HostVld, O_ISAVld, O_HostLast, O_ChipRdy, O_MemWrEn, O_Err}, 6'b0);
    chk("mid_rst_addr", {O_GntIdx, O_MemAddr}, 35'h0);
    @(negedge I_OffClk);
    rst_n = 1'b0;

    I_CfgRdy = 6'b100001;
    sendCmd(1'b0, 32'h300, 16'd1);
    chk("prio_cmd_beat", {O_HostVld, O_ISAVld, O_HostLast, O_MemAddr}, {3'b101, 32'h300});
    runIsa(6'b100001, 6'b100001, 0, 0, 16, waits);
`ifdef ISA_RR_ARB_EN
    runIsa(6'b100001, 6'b0, 5, 31, 1, waits);
`else
    runIsa(6'b100001, 6'b0, 0, 16, 16, waits);
`endif
    chk("final_idle", {O_HostVld, O_ChipRdy, O_MemWrEn}, 3'b000);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
